// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// AHB-Lite default slave: answers every transfer that decodes to no mapped
// region. With RESP_ERR=1 it returns the two-cycle ERROR response; with
// RESP_ERR=0 it returns zero-wait OKAY (reads return 0, writes are dropped).
// It also records the most recent unmapped access on side-band debug outputs.
//
// Optional feature macro: AHB_DFLT_CAPTURE_EN
//   defined   : err_addr/err_write/err_size capture, saturating err_count,
//               err_irq pulse and err_clr are built.
//   undefined : those outputs are tied to 0 and err_clr is ignored.
//
// Ports
//   HCLK, HRESETn    clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY   AHB slave inputs
//   HREADYOUT, HRDATA, HRESP                             AHB slave outputs
//   err_addr, err_write, err_size   attributes of the last accepted transfer
//   err_count        accepted transfers since reset/clear (saturating)
//   err_irq          one-cycle pulse per accepted transfer
//   err_clr          synchronous clear of err_count
// ---------------------------------------------------------------------------
module ahb_default_slave #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CNT_W    = 8,
   parameter bit          RESP_ERR = 1'b1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic [2:0]        HSIZE,
   input  logic              HWRITE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HRESP,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_write,
   output logic [2:0]        err_size,
   output logic [CNT_W-1:0]  err_count,
   output logic              err_irq,
   input  logic              err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   hreadyout_d, hresp_d;
   logic   accept_c;

   // NONSEQ/SEQ address phase completing while selected
   assign accept_c = HSEL & HREADY & HTRANS[1];

   // read data is always zero
   assign HRDATA = '0;

   // state register; bus outputs are registered alongside the state
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
      end else begin
         state_q   <= state_d;
         HREADYOUT <= hreadyout_d;
         HRESP     <= hresp_d;
      end
   end

   // next state and next bus response
   always_comb begin
      state_d     = state_q;
      hreadyout_d = 1'b1;
      hresp_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (RESP_ERR && accept_c) begin
               state_d     = ST_ERR1;
               hreadyout_d = 1'b0;
               hresp_d     = 1'b1;
            end
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b1;
         end
         ST_ERR2: begin
            // a new transfer's address phase completes alongside ERR2
            if (RESP_ERR && accept_c) begin
               state_d     = ST_ERR1;
               hreadyout_d = 1'b0;
               hresp_d     = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef AHB_DFLT_CAPTURE_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // capture of the last accepted transfer, saturating counter, irq pulse
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_addr  <= '0;
         err_write <= 1'b0;
         err_size  <= '0;
         err_count <= '0;
         err_irq   <= 1'b0;
      end else begin
         err_irq <= accept_c;
         if (accept_c) begin
            err_addr  <= HADDR;
            err_write <= HWRITE;
            err_size  <= HSIZE;
         end
         // clear wins over the old value but still counts a same-cycle accept
         if (err_clr) begin
            err_count <= CNT_W'(accept_c);
         end else if (accept_c && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

   logic unused_c;
   assign unused_c = ^{HWDATA, HTRANS[0]};
`else
   assign err_addr  = '0;
   assign err_write = 1'b0;
   assign err_size  = '0;
   assign err_count = '0;
   assign err_irq   = 1'b0;

   logic unused_c;
   assign unused_c = ^{HWDATA, HTRANS[0], HADDR, HWRITE, HSIZE, err_clr};
`endif

endmodule

// File: doc/ahb_default_slave.md
# ahb_default_slave

Parametrised AHB-Lite default slave. It answers every transfer that falls outside all mapped regions of the bus matrix. It generates the protocol-correct two-cycle ERROR response (or, optionally, a zero-wait OKAY read-as-zero / write-ignored response). It also records the most recent unmapped access on side-band outputs for debug and interrupt logic.

## Interface

Parameters:
- ADDR_W, 16, width of HADDR and err_addr
- DATA_W, 32, width of HWDATA/HRDATA
- CNT_W, 8, width of the saturating error counter
- RESP_ERR, 1, 1 = two-cycle ERROR response; 0 = zero-wait OKAY, reads return 0, writes dropped

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; one clock, reset is asynchronous and active-low
- HSEL  in  1  device select
- HADDR  in  ADDR_W  address
- HTRANS  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HSIZE  in  3  transfer size
- HWRITE  in  1  write control
- HWDATA  in  DATA_W  write data (ignored)
- HREADY  in  1  bus ready (previous data phase done)
- HREADYOUT  out  1  slave ready
- HRDATA  out  DATA_W  read data, constant 0
- HRESP  out  1  response, 0 = OKAY, 1 = ERROR
- err_addr  out  ADDR_W  HADDR of last accepted transfer
- err_write  out  1  HWRITE of last accepted transfer
- err_size  out  3  HSIZE of last accepted transfer
- err_count  out  CNT_W  accepted transfers since reset/clear, saturating
- err_irq  out  1  one-cycle pulse per accepted transfer
- err_clr  in  1  synchronous clear of err_count

## Operation

- Accept = HSEL & HREADY & HTRANS[1], sampled at the rising edge. IDLE and BUSY are never accepted and always get zero-wait OKAY.
- FSM states: IDLE, ERR1, ERR2. Used only when RESP_ERR=1; with RESP_ERR=0 the FSM stays in IDLE.
- IDLE: HREADYOUT=1, HRESP=0. On accept, go to ERR1.
- ERR1: HREADYOUT=0, HRESP=1. Unconditionally go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. On accept (the new address phase completes this cycle), go to ERR1; otherwise go to IDLE.
- The master may drop HTRANS to IDLE during ERR1. No accept happens in ERR1 because HREADY is low.
- HREADYOUT and HRESP are decoded from registered state only. There is no combinational path from the inputs.
- HRDATA is tied to 0 in all modes.
- Capture on every accept, in both modes:
  - err_addr, err_write and err_size load from HADDR, HWRITE and HSIZE.
  - err_count increments, saturating at 2^CNT_W-1.
  - err_irq is high for the following cycle.
- err_clr: err_count becomes 0 next cycle. If err_clr and accept occur in the same cycle, err_count becomes 1. err_addr, err_write and err_size are not cleared.

## Timing

- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, err_addr=0, err_write=0, err_size=0, err_count=0, err_irq=0.
- Accept at edge k (RESP_ERR=1): ERR1 occupies cycle k..k+1 and ERR2 occupies k+1..k+2. The master samples ERROR with HREADY=1 at edge k+2.
- Back-to-back errors: there is a 2-cycle period per transfer with no IDLE cycle between responses.
- RESP_ERR=0: the data phase completes at edge k+1 with OKAY.
- Capture outputs update at edge k. err_irq is high k..k+1.
- Reset asserted mid-response (ERR1 or ERR2): immediately return to IDLE with HREADYOUT=1 and HRESP=0. Any pending response is discarded.

## Configuration

- Macro AHB_DFLT_CAPTURE_EN.
- Defined: capture registers, counter, err_irq and err_clr logic are built as described.
- Undefined: err_addr, err_write, err_size, err_count and err_irq are tied to 0 and err_clr is ignored. The bus response behaviour is identical.

## Test plan

- Reset, then idle bus with HSEL=1 and HTRANS=IDLE for 5 cycles -> HREADYOUT=1, HRESP=0, err_count=0, err_irq never high.
- RESP_ERR=1, single NONSEQ read at HADDR=0x1234 -> cycle+1: HREADYOUT=0, HRESP=1; cycle+2: HREADYOUT=1, HRESP=1; then OKAY. Also err_addr=0x1234, err_write=0, err_count=1, one err_irq pulse.
- RESP_ERR=1, two back-to-back NONSEQ writes to 0x0010 and 0x0020 -> responses ERR1, ERR2, ERR1, ERR2 with no gap; err_addr=0x0020, err_write=1, err_count=2.
- Master cancels during ERR1 (HTRANS to IDLE) -> ERR2 is followed by IDLE and no extra count.
- RESP_ERR=0, CNT_W=2, five NONSEQ reads -> every transfer gets zero-wait OKAY with HRDATA=0; err_count saturates at 3.
- err_clr asserted in the same cycle as an accept -> err_count=1. Asserting HRESETn low during ERR1 -> HREADYOUT=1 and HRESP=0 immediately, and all err_* outputs are 0.
